// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game: defaults, round FSM states, bit counting.
package game_pkg;

    localparam int unsigned    NUM_MOLES = 8;
    localparam logic [7:0]     LFSR_SEED = 8'hA5;
    localparam logic [7:0]     LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StTally
    } state_e;

    // Fixed 32-bit input so any mole count up to 32 can share one helper.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mole_round_engine_sw_sync.sv
// Switch front end: two-flop synchroniser plus previous-value register;
// toggle flags a change in either direction.
module sw_sync_edge #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] toggle
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign toggle = sync2_q ^ prev_q;

endmodule

// File: rtl/mole_round_engine.sv
// Round engine: shows an LFSR mole pattern each round, classifies switch toggles
// as hits or misses, and emits the round's increments one clock after game_tick.
module mole_round_engine
    import game_pkg::state_e, game_pkg::StIdle, game_pkg::StRun, game_pkg::StTally,
           game_pkg::popcount;
#(
    parameter int unsigned              NUM_MOLES = game_pkg::NUM_MOLES,
    parameter int unsigned              INC_W     = 4,
    parameter logic [NUM_MOLES-1:0]     LFSR_SEED = game_pkg::LFSR_SEED,
    parameter logic [NUM_MOLES-1:0]     LFSR_TAPS = game_pkg::LFSR_TAPS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 game_tick,
    input  logic [NUM_MOLES-1:0] sw,
    output logic [NUM_MOLES-1:0] led,
    output logic [INC_W-1:0]     score_inc,
    output logic [INC_W-1:0]     miss_inc,
    output logic                 inc_valid
);

    // The LFSR is as wide as the mole field so each state maps directly onto a mask.
    function automatic logic [NUM_MOLES-1:0] lfsr_next(input logic [NUM_MOLES-1:0] cur);
        logic [NUM_MOLES-1:0] nxt;
        nxt = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
        return (nxt == '0) ? LFSR_SEED : nxt;
    endfunction

    state_e               state_q, state_d;
    logic [NUM_MOLES-1:0] lfsr_q, lfsr_d;
    logic [NUM_MOLES-1:0] mole_q, mole_d;
    logic [NUM_MOLES-1:0] hit_q, hit_d;
    logic [INC_W-1:0]     miss_cnt_q, miss_cnt_d;
    logic [INC_W-1:0]     score_q, score_d;
    logic [INC_W-1:0]     miss_inc_q, miss_inc_d;

    logic [NUM_MOLES-1:0] toggle;
    logic [NUM_MOLES-1:0] hits;
    logic [NUM_MOLES-1:0] misses;
    logic [INC_W:0]       miss_sum;
    logic [INC_W-1:0]     miss_sat;

    sw_sync_edge #(
        .WIDTH (NUM_MOLES)
    ) u_sw_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw     (sw),
        .toggle (toggle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lfsr_q     <= LFSR_SEED;
            mole_q     <= '0;
            hit_q      <= '0;
            miss_cnt_q <= '0;
            score_q    <= '0;
            miss_inc_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            mole_q     <= mole_d;
            hit_q      <= hit_d;
            miss_cnt_q <= miss_cnt_d;
            score_q    <= score_d;
            miss_inc_q <= miss_inc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        mole_d     = mole_q;
        hit_d      = hit_q;
        miss_cnt_d = miss_cnt_q;
        score_d    = score_q;
        miss_inc_d = miss_inc_q;

        // Re-toggling an already whacked mole lands in neither set.
        hits     = toggle & mole_q & ~hit_q;
        misses   = toggle & ~mole_q;
        miss_sum = {1'b0, miss_cnt_q} + (INC_W+1)'(popcount(32'(misses)));
        miss_sat = miss_sum[INC_W] ? '1 : miss_sum[INC_W-1:0];

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    mole_d     = lfsr_q;
                    lfsr_d     = lfsr_next(lfsr_q);
                    hit_d      = '0;
                    miss_cnt_d = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                // A tick closes the round even if enable drops in the same cycle.
                if (game_tick) begin
                    score_d    = INC_W'(popcount(32'(hit_q | hits)));
                    miss_inc_d = miss_sat;
                    state_d    = StTally;
                end else if (!enable) begin
                    mole_d     = '0;
                    hit_d      = '0;
                    miss_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    hit_d      = hit_q | hits;
                    miss_cnt_d = miss_sat;
                end
            end
            StTally: begin
                mole_d     = enable ? lfsr_q : '0;
                lfsr_d     = lfsr_next(lfsr_q);
                hit_d      = '0;
                miss_cnt_d = '0;
                state_d    = enable ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign led       = (state_q == StIdle) ? '0 : (mole_q & ~hit_q);
    assign inc_valid = (state_q == StTally);
    assign score_inc = score_q;
    assign miss_inc  = miss_inc_q;

endmodule

// File: tb/tb_mole_round_engine.sv
// Directed bench for mole_round_engine with a round-level reference model checked every cycle.
module tb_mole_round_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       game_tick = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] led;
    logic [3:0] score_inc;
    logic [3:0] miss_inc;
    logic       inc_valid;

    int checks = 0;
    int failures = 0;

    mole_round_engine #(
        .NUM_MOLES (8),
        .INC_W     (4),
        .LFSR_SEED (8'hA5),
        .LFSR_TAPS (8'hB8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .game_tick (game_tick),
        .sw        (sw),
        .led       (led),
        .score_inc (score_inc),
        .miss_inc  (miss_inc),
        .inc_valid (inc_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (round-level view) ----------------
    bit         m_running;     // a round is open
    bit         m_closing;     // the cycle after the tick
    logic [7:0] m_next_pat;    // pattern the next round will show
    logic [7:0] m_pattern;     // current round's moles
    logic [7:0] m_whacked;     // moles hit this round
    int         m_wrong;       // wrong toggles this round
    int         m_score_out;
    int         m_miss_out;
    logic [7:0] pin_seen [3];  // pins as seen after 1, 2, 3 clocks

    function automatic logic [7:0] pattern_after(input logic [7:0] p);
        logic [7:0] n;
        n = p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
        if (n == 8'h00) n = 8'hA5;
        return n;
    endfunction

    function automatic int min15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        m_running = 0; m_closing = 0;
        m_next_pat = 8'hA5; m_pattern = 8'h00; m_whacked = 8'h00; m_wrong = 0;
        m_score_out = 0; m_miss_out = 0;
        for (int i = 0; i < 3; i++) pin_seen[i] = 8'h00;
    endtask

    task automatic open_round();
        m_pattern  = m_next_pat;
        m_next_pat = pattern_after(m_next_pat);
        m_whacked  = 8'h00;
        m_wrong    = 0;
        m_running  = 1;
    endtask

    task automatic model_step();
        logic [7:0] changed;
        logic [7:0] fresh_hits;
        int         wrong_now;
        int         total_hits;
        changed = pin_seen[1] ^ pin_seen[2];
        pin_seen[2] = pin_seen[1];
        pin_seen[1] = pin_seen[0];
        pin_seen[0] = sw;
        if (m_closing) begin
            m_closing = 0;
            open_round();
            if (!enable) begin
                m_running = 0;
                m_pattern = 8'h00;
            end
        end else if (m_running) begin
            fresh_hits = 8'h00;
            wrong_now  = 0;
            for (int i = 0; i < 8; i++) begin
                if (changed[i] && !m_pattern[i]) wrong_now++;
                if (changed[i] && m_pattern[i] && !m_whacked[i]) fresh_hits[i] = 1'b1;
            end
            if (game_tick) begin
                total_hits = 0;
                for (int i = 0; i < 8; i++) if (m_whacked[i] || fresh_hits[i]) total_hits++;
                m_score_out = total_hits;
                m_miss_out  = min15(m_wrong + wrong_now);
                m_running   = 0;
                m_closing   = 1;
            end else if (!enable) begin
                m_running = 0;
                m_pattern = 8'h00;
                m_whacked = 8'h00;
                m_wrong   = 0;
            end else begin
                m_whacked = m_whacked | fresh_hits;
                m_wrong   = min15(m_wrong + wrong_now);
            end
        end else if (enable) begin
            open_round();
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("led", 32'(led), (m_running || m_closing) ? 32'(m_pattern & ~m_whacked) : 32'h0);
            check("inc_valid", 32'(inc_valid), 32'(m_closing));
            check("score_inc", 32'(score_inc), 32'(m_score_out));
            check("miss_inc", 32'(miss_inc), 32'(m_miss_out));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; game_tick = 1'b0; sw = 8'h00;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic start_round();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("first_led", 32'(led), 32'hA5);
    endtask

    task automatic flip(input logic [7:0] mask);
        @(negedge clk);
        sw = sw ^ mask;
    endtask

    // Leaves the bench on the falling edge where inc_valid should be high.
    task automatic tick();
        @(negedge clk);
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic check_tally(input string tag, input int sc, input int ms);
        check({tag, "_valid"}, 32'(inc_valid), 32'h1);
        check({tag, "_score"}, 32'(score_inc), 32'(sc));
        check({tag, "_miss"},  32'(miss_inc),  32'(ms));
    endtask

    logic [7:0] seq [3];

    initial begin
        seq[0] = 8'hEA; seq[1] = 8'h75; seq[2] = 8'h82;

        // Reset values, two hits, then next pattern.
        do_reset();
        check("rst_led", 32'(led), 32'h0);
        check("rst_valid", 32'(inc_valid), 32'h0);
        check("rst_score", 32'(score_inc), 32'h0);
        start_round();
        flip(8'h05); wait_cyc(3);
        check("two_hits_led", 32'(led), 32'hA0);
        tick();
        check_tally("two_hits", 2, 0);
        @(negedge clk);
        check("second_pattern", 32'(led), 32'hEA);
        check("valid_one_cycle", 32'(inc_valid), 32'h0);
        check("score_hold", 32'(score_inc), 32'h2);

        // Toggle on a lit mole in the tick cycle counts for the closing round.
        flip(8'h02); wait_cyc(1);
        @(negedge clk); game_tick = 1'b1;
        @(negedge clk); game_tick = 1'b0;
        check_tally("tick_cycle_hit", 1, 0);
        @(negedge clk);
        check("third_pattern", 32'(led), 32'h75);

        // Simultaneous misses.
        do_reset(); start_round();
        flip(8'h0A); wait_cyc(3);
        check("miss_led", 32'(led), 32'hA5);
        tick();
        check_tally("two_misses", 0, 2);

        // Up then down on the same mole: one hit only.
        do_reset(); start_round();
        flip(8'h01); wait_cyc(3);
        check("whack_led", 32'(led), 32'hA4);
        flip(8'h01); wait_cyc(3);
        check("rewhack_led", 32'(led), 32'hA4);
        tick();
        check_tally("rewhack", 1, 0);

        // Miss counter saturation: 18 wrong toggles in round 0xEA (unlit bits 0,2,4).
        @(negedge clk);
        for (int i = 0; i < 6; i++) flip(8'h15);
        wait_cyc(3);
        tick();
        check_tally("miss_sat", 0, 15);

        // Quiet rounds walk the pattern sequence.
        do_reset(); start_round();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_tally("quiet", 0, 0);
            @(negedge clk);
            check("quiet_led", 32'(led), 32'(seq[k]));
        end

        // Reset mid-round with three hits pending.
        do_reset(); start_round();
        flip(8'h25); wait_cyc(3);
        check("pending_led", 32'(led), 32'h80);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_valid", 32'(inc_valid), 32'h0);
        wait_cyc(2);
        sw = 8'h00; enable = 1'b0;
        rst_n = 1'b1;
        wait_cyc(4);
        start_round();
        tick();
        check_tally("after_rst", 0, 0);

        // Drop enable mid-round, toggle while idle, then re-enable.
        do_reset(); start_round();
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        check("abort_led", 32'(led), 32'h0);
        check("abort_valid", 32'(inc_valid), 32'h0);
        for (int i = 0; i < 20; i++) flip(8'(1 << (i % 8)));
        wait_cyc(5);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_led", 32'(led), 32'hEA);
        tick();
        check_tally("reenable", 0, 0);

        wait_cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
